// File: rtl/neural_network_2layer_softmax.sv
// 2-layer MLP (Dense+ReLU, Dense) with softmax over a batch, one MAC and one restoring divider; optional DENSE1_DBG_EN exposes hidden activations.
// Latency per sample: HIDDEN1*IN_SIZE + OUT_SIZE*HIDDEN1 + 1 + OUT_SIZE + OUT_SIZE*(WIDTH+1) cycles; done one cycle after the last division.
// No backpressure: start is honoured only in IDLE and ignored while busy; array inputs must be held stable while busy.
module neural_network_2layer_softmax #(
    parameter int IN_SIZE  = 2,
    parameter int HIDDEN1  = 64,
    parameter int OUT_SIZE = 3,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int BATCH    = 300
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic signed [WIDTH-1:0] in_vec      [BATCH][IN_SIZE],
    input  logic signed [WIDTH-1:0] W1          [HIDDEN1][IN_SIZE],
    input  logic signed [WIDTH-1:0] B1          [HIDDEN1],
    input  logic signed [WIDTH-1:0] W2          [OUT_SIZE][HIDDEN1],
    input  logic signed [WIDTH-1:0] B2          [OUT_SIZE],
    output logic signed [WIDTH-1:0] dense1_dbg  [BATCH][HIDDEN1],
    output logic signed [WIDTH-1:0] softmax_out [BATCH][OUT_SIZE]
);

    localparam int AW  = 2*WIDTH + 8;
    localparam int PW  = 2*WIDTH;
    localparam int DVW = WIDTH + 1;
    localparam int RW  = 2*WIDTH;
    localparam int DW  = WIDTH + 2;
    localparam int BW  = (BATCH    > 1) ? $clog2(BATCH)    : 1;
    localparam int IW  = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
    localparam int HW  = (HIDDEN1  > 1) ? $clog2(HIDDEN1)  : 1;
    localparam int OW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int CW  = (HW > IW) ? HW : IW;
    localparam int NW  = (HW > OW) ? HW : OW;
    localparam int DCW = $clog2(DVW + 1);
    localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (WIDTH-1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - 1;

    typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_MAX, S_EXP, S_DIV, S_DONE} state_t;

    state_t state_q, state_d;

    logic [BW-1:0]           samp;
    logic [NW-1:0]           nrn;
    logic [CW-1:0]           term;
    logic [DCW-1:0]          dcnt;
    logic signed [AW-1:0]    acc, acc_nx, acc_sh, biased;
    logic signed [WIDTH-1:0] mac_a, mac_b, bias, sat_val, relu_val;
    logic signed [PW-1:0]    mac_p;
    logic signed [WIDTH-1:0] hid   [HIDDEN1];
    logic signed [WIDTH-1:0] logit [OUT_SIZE];
    logic signed [WIDTH-1:0] zmax, zmax_nx;
    logic [WIDTH-1:0]        ev    [OUT_SIZE];
    logic [WIDTH-1:0]        e_val;
    logic signed [DW-1:0]    diff;
    logic signed [31:0]      ymul, yq;
    logic [31:0]             mag, kexp, etmp;
    logic [FRAC-1:0]         ffrac;
    logic [RW-1:0]           esum, rem, rem_cur, rem_sh, rem_nx;
    logic [DVW-1:0]          dq, dq_cur, dq_nx;
    logic                    div_ge;
    logic                    term_last_l1, term_last_l2, nrn_last_h, nrn_last_o, samp_last, dcnt_last;

    assign term_last_l1 = (term == CW'(IN_SIZE-1));
    assign term_last_l2 = (term == CW'(HIDDEN1-1));
    assign nrn_last_h   = (nrn  == NW'(HIDDEN1-1));
    assign nrn_last_o   = (nrn  == NW'(OUT_SIZE-1));
    assign samp_last    = (samp == BW'(BATCH-1));
    assign dcnt_last    = (dcnt == DCW'(DVW-1));

    // Shared MAC: layer 1 reads weights x inputs, layer 2 reads weights x hidden buffer.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        bias  = '0;
        if (state_q == S_L2) begin
            mac_a = W2[nrn[OW-1:0]][term[HW-1:0]];
            mac_b = hid[term[HW-1:0]];
            bias  = B2[nrn[OW-1:0]];
        end else begin
            mac_a = W1[nrn[HW-1:0]][term[IW-1:0]];
            mac_b = in_vec[samp][term[IW-1:0]];
            bias  = B1[nrn[HW-1:0]];
        end
    end

    always_comb begin
        mac_p  = mac_a * mac_b;
        acc_nx = acc + mac_p;
        acc_sh = acc_nx >>> FRAC;
        biased = acc_sh + bias;
        if (biased > SAT_HI)
            sat_val = SAT_HI[WIDTH-1:0];
        else if (biased < SAT_LO)
            sat_val = SAT_LO[WIDTH-1:0];
        else
            sat_val = biased[WIDTH-1:0];
        relu_val = (sat_val < 0) ? '0 : sat_val;
    end

    // Lowest index wins ties because only a strictly larger logit replaces the running max.
    always_comb begin
        zmax_nx = logit[0];
        for (int i = 1; i < OUT_SIZE; i++) begin
            if (logit[i] > zmax_nx)
                zmax_nx = logit[i];
        end
    end

    // exp(d) ~ 2^(d*log2e): integer part as a shift, fractional part as a linear 1 - f/2 term.
    always_comb begin
        diff  = DW'(logit[nrn[OW-1:0]]) - DW'(zmax);
        ymul  = 32'(diff) * 32'sd369;
        yq    = ymul >>> FRAC;
        mag   = -yq;
        kexp  = mag >> FRAC;
        ffrac = mag[FRAC-1:0];
        etmp  = (32'd1 << FRAC) - 32'(ffrac >> 1);
        e_val = (kexp >= 32'(WIDTH)) ? '0 : WIDTH'(etmp >> kexp);
    end

    // Restoring divider; the first step takes its operands straight from the exp buffer.
    always_comb begin
        dq_cur  = (dcnt == '0) ? (DVW'(ev[nrn[OW-1:0]]) << FRAC) : dq;
        rem_cur = (dcnt == '0) ? '0 : rem;
        rem_sh  = {rem_cur[RW-2:0], dq_cur[DVW-1]};
        div_ge  = (rem_sh >= esum);
        rem_nx  = div_ge ? (rem_sh - esum) : rem_sh;
        dq_nx   = {dq_cur[DVW-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = S_L1;
            end
            S_L1:  if (term_last_l1 && nrn_last_h) state_d = S_L2;
            S_L2:  if (term_last_l2 && nrn_last_o) state_d = S_MAX;
            S_MAX: state_d = S_EXP;
            S_EXP: if (nrn_last_o) state_d = S_DIV;
            S_DIV: if (dcnt_last && nrn_last_o) state_d = samp_last ? S_DONE : S_L1;
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            nrn  <= '0;
            term <= '0;
            dcnt <= '0;
            acc  <= '0;
            zmax <= '0;
            esum <= '0;
            rem  <= '0;
            dq   <= '0;
            for (int j = 0; j < HIDDEN1; j++)
                hid[j] <= '0;
            for (int i = 0; i < OUT_SIZE; i++) begin
                logit[i] <= '0;
                ev[i]    <= '0;
            end
            for (int b = 0; b < BATCH; b++)
                for (int i = 0; i < OUT_SIZE; i++)
                    softmax_out[b][i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        samp <= '0;
                        nrn  <= '0;
                        term <= '0;
                        acc  <= '0;
                    end
                end
                S_L1: begin
                    if (term_last_l1) begin
                        hid[nrn[HW-1:0]] <= relu_val;
                        acc  <= '0;
                        term <= '0;
                        nrn  <= nrn_last_h ? '0 : nrn + 1'b1;
                    end else begin
                        acc  <= acc_nx;
                        term <= term + 1'b1;
                    end
                end
                S_L2: begin
                    if (term_last_l2) begin
                        logit[nrn[OW-1:0]] <= sat_val;
                        acc  <= '0;
                        term <= '0;
                        nrn  <= nrn_last_o ? '0 : nrn + 1'b1;
                    end else begin
                        acc  <= acc_nx;
                        term <= term + 1'b1;
                    end
                end
                S_MAX: begin
                    zmax <= zmax_nx;
                    esum <= '0;
                    nrn  <= '0;
                end
                S_EXP: begin
                    ev[nrn[OW-1:0]] <= e_val;
                    esum <= esum + RW'(e_val);
                    nrn  <= nrn_last_o ? '0 : nrn + 1'b1;
                    dcnt <= '0;
                end
                S_DIV: begin
                    rem <= rem_nx;
                    dq  <= dq_nx;
                    if (dcnt_last) begin
                        softmax_out[samp][nrn[OW-1:0]] <= WIDTH'(dq_nx);
                        dcnt <= '0;
                        if (nrn_last_o) begin
                            nrn  <= '0;
                            term <= '0;
                            acc  <= '0;
                            samp <= samp_last ? samp : samp + 1'b1;
                        end else begin
                            nrn <= nrn + 1'b1;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DENSE1_DBG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BATCH; b++)
                for (int j = 0; j < HIDDEN1; j++)
                    dense1_dbg[b][j] <= '0;
        end else if (state_q == S_L1 && term_last_l1) begin
            dense1_dbg[samp][nrn[HW-1:0]] <= relu_val;
        end
    end
`else
    for (genvar b = 0; b < BATCH; b++) begin : g_dbg_b
        for (genvar j = 0; j < HIDDEN1; j++) begin : g_dbg_j
            assign dense1_dbg[b][j] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_neural_network_2layer_softmax.sv
// Directed and randomized checks of the MLP/softmax engine against an integer reference model.
module tb_neural_network_2layer_softmax;

    localparam int IN_SIZE  = 2;
    localparam int HIDDEN1  = 8;
    localparam int OUT_SIZE = 3;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int BATCH    = 4;
    localparam int LIMIT    = 4000;

    logic clk, rst_n, start, busy, done;
    logic signed [WIDTH-1:0] in_vec      [BATCH][IN_SIZE];
    logic signed [WIDTH-1:0] W1          [HIDDEN1][IN_SIZE];
    logic signed [WIDTH-1:0] B1          [HIDDEN1];
    logic signed [WIDTH-1:0] W2          [OUT_SIZE][HIDDEN1];
    logic signed [WIDTH-1:0] B2          [OUT_SIZE];
    logic signed [WIDTH-1:0] dense1_dbg  [BATCH][HIDDEN1];
    logic signed [WIDTH-1:0] softmax_out [BATCH][OUT_SIZE];

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int exp_sm  [BATCH][OUT_SIZE];
    int prev_sm [BATCH][OUT_SIZE];
    int exp_h   [BATCH][HIDDEN1];

    neural_network_2layer_softmax #(
        .IN_SIZE(IN_SIZE), .HIDDEN1(HIDDEN1), .OUT_SIZE(OUT_SIZE),
        .WIDTH(WIDTH), .FRAC(FRAC), .BATCH(BATCH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_vec(in_vec), .W1(W1), .B1(B1), .W2(W2), .B2(B2),
        .dense1_dbg(dense1_dbg), .softmax_out(softmax_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic signed [15:0] rnd(input int span);
        int v;
        v = int'($urandom_range(2*span, 0)) - span;
        return 16'(v);
    endfunction

    function automatic longint satw(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: plain integer arithmetic straight from the fixed-point rules.
    task automatic model_run();
        longint acc, m, d, y, mag, sh, f, sum;
        longint hv [HIDDEN1];
        longint z  [OUT_SIZE];
        longint e  [OUT_SIZE];
        for (int b = 0; b < BATCH; b++) begin
            for (int j = 0; j < HIDDEN1; j++) begin
                acc = 0;
                for (int k = 0; k < IN_SIZE; k++)
                    acc += longint'(W1[j][k]) * longint'(in_vec[b][k]);
                hv[j] = satw((acc >>> 8) + longint'(B1[j]));
                if (hv[j] < 0) hv[j] = 0;
                exp_h[b][j] = int'(hv[j]);
            end
            for (int i = 0; i < OUT_SIZE; i++) begin
                acc = 0;
                for (int j = 0; j < HIDDEN1; j++)
                    acc += longint'(W2[i][j]) * hv[j];
                z[i] = satw((acc >>> 8) + longint'(B2[i]));
            end
            m = z[0];
            for (int i = 1; i < OUT_SIZE; i++) if (z[i] > m) m = z[i];
            sum = 0;
            for (int i = 0; i < OUT_SIZE; i++) begin
                d   = z[i] - m;
                y   = (d * 369) >>> 8;
                mag = -y;
                sh  = mag / 256;
                f   = mag % 256;
                e[i] = (sh >= 16) ? 0 : ((256 - f / 2) >> sh);
                sum += e[i];
            end
            for (int i = 0; i < OUT_SIZE; i++)
                exp_sm[b][i] = int'((e[i] * 256) / sum);
        end
    endtask

    task automatic clear_exp();
        for (int b = 0; b < BATCH; b++) begin
            for (int i = 0; i < OUT_SIZE; i++) exp_sm[b][i] = 0;
            for (int j = 0; j < HIDDEN1; j++) exp_h[b][j] = 0;
        end
    endtask

    task automatic zero_all();
        for (int b = 0; b < BATCH; b++) for (int k = 0; k < IN_SIZE; k++) in_vec[b][k] = '0;
        for (int j = 0; j < HIDDEN1; j++) begin
            B1[j] = '0;
            for (int k = 0; k < IN_SIZE; k++) W1[j][k] = '0;
        end
        for (int i = 0; i < OUT_SIZE; i++) begin
            B2[i] = '0;
            for (int j = 0; j < HIDDEN1; j++) W2[i][j] = '0;
        end
    endtask

    task automatic rand_w2();
        for (int i = 0; i < OUT_SIZE; i++) for (int j = 0; j < HIDDEN1; j++) W2[i][j] = rnd(256);
    endtask

    task automatic rand_all();
        for (int b = 0; b < BATCH; b++) for (int k = 0; k < IN_SIZE; k++) in_vec[b][k] = rnd(512);
        for (int j = 0; j < HIDDEN1; j++) begin
            B1[j] = rnd(256);
            for (int k = 0; k < IN_SIZE; k++) W1[j][k] = rnd(256);
        end
        for (int i = 0; i < OUT_SIZE; i++) B2[i] = rnd(256);
        rand_w2();
    endtask

    task automatic check_outputs(input string tag);
        int expd;
        for (int b = 0; b < BATCH; b++)
            for (int i = 0; i < OUT_SIZE; i++)
                chk($sformatf("%s.sm[%0d][%0d]", tag, b, i), softmax_out[b][i], exp_sm[b][i]);
        for (int b = 0; b < BATCH; b++)
            for (int j = 0; j < HIDDEN1; j++) begin
`ifdef DENSE1_DBG_EN
                expd = exp_h[b][j];
`else
                expd = 0;
`endif
                chk($sformatf("%s.h[%0d][%0d]", tag, b, j), dense1_dbg[b][j], expd);
            end
    endtask

    // One accepted run; optional stray start pulses while busy and a mid-run retention check.
    task automatic run_and_wait(input string tag, input bit stray, input bit mid);
        int c0, cyc;
        prev_sm = exp_sm;
        model_run();
        c0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy_after_start"}, busy, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            start = stray && (cyc % 37 == 5);
            @(negedge clk);
            cyc++;
            if (mid && cyc == 150) begin
                for (int i = 0; i < OUT_SIZE; i++) begin
                    chk($sformatf("%s.mid_new[%0d]", tag, i), softmax_out[0][i], exp_sm[0][i]);
                    chk($sformatf("%s.mid_old[%0d]", tag, i), softmax_out[BATCH-1][i], prev_sm[BATCH-1][i]);
                end
            end
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, done, 1);
        chk({tag, ".busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, done, 0);
        chk({tag, ".done_count"}, done_cnt - c0, 1);
        repeat (10) @(negedge clk);
        chk({tag, ".idle_after"}, busy, 0);
        chk({tag, ".no_extra_done"}, done_cnt - c0, 1);
    endtask

    initial begin
        int c0;
        rst_n = 1'b1;
        start = 1'b0;
        zero_all();
        clear_exp();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        check_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All zero: uniform 85 everywhere.
        run_and_wait("t1", 0, 0);
        check_outputs("t1");
        chk("t1.const", softmax_out[BATCH-1][1], 85);

        // Logits (512,0,0) -> (201,27,27).
        zero_all();
        B1[0] = 16'sd256;
        W2[0][0] = 16'sd512;
        run_and_wait("t2", 0, 0);
        check_outputs("t2");
        chk("t2.c0", softmax_out[0][0], 201);
        chk("t2.c1", softmax_out[0][1], 27);
        chk("t2.c2", softmax_out[2][2], 27);

        // Negative hidden pre-activation must be clipped by ReLU.
        zero_all();
        B1[0] = -16'sd256;
        rand_w2();
        run_and_wait("t3", 0, 0);
        check_outputs("t3");
        chk("t3.relu", dense1_dbg[1][0], 0);

        // Hidden saturation.
        zero_all();
        W1[0][0] = 16'sd32767;
        for (int b = 0; b < BATCH; b++) in_vec[b][0] = 16'sd32767;
        rand_w2();
        run_and_wait("t4", 0, 0);
        check_outputs("t4");

        rand_all();
        run_and_wait("r1", 0, 1);
        check_outputs("r1");
        rand_all();
        run_and_wait("r2", 0, 0);
        check_outputs("r2");

        // Reset abort inside layer 2 of sample 0.
        rand_all();
        run_and_wait("t5a", 0, 0);
        check_outputs("t5a");
        c0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (24) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.abort_busy", busy, 0);
        chk("t5.abort_done", done, 0);
        clear_exp();
        check_outputs("t5.abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5.no_done", done_cnt - c0, 0);
        chk("t5.idle", busy, 0);
        run_and_wait("t5.restart", 0, 1);
        check_outputs("t5.restart");

        // Start pulses while busy are ignored.
        rand_all();
        run_and_wait("t6", 1, 0);
        check_outputs("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
